echo_indication_output: RTL and testbench

- Transmit end of the echo indication pipe: accepts `indication$heard(meth, v)` method calls and serializes each into a 3-beat, 32-bit message on an outbound `pipe$enq` port.
- Buffers calls in a DEPTH-entry FIFO so the caller is decoupled from pipe backpressure.
- Produces the framing that the matching input-side deserializer decodes.
- Sits between the echo core (caller) and the portal/transport pipe.

---
 rtl/echo_indication_output.sv | 94 +++++++++
 tb/tb_echo_indication_output.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/echo_indication_output.sv
// rtl/echo_indication_output.sv - serializes heard(meth, v) calls into 3-beat pipe messages
// A small FIFO decouples the caller from pipe backpressure; the beat FSM frames each entry.
module echo_indication_output #(
  parameter int DEPTH = 4,
  parameter int MID   = 1,
  parameter int LEN   = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        indication_heard__ENA,
  input  logic [31:0] indication_heard_meth,
  input  logic [31:0] indication_heard_v,
  output logic        indication_heard__RDY,
  output logic        pipe_enq__ENA,
  output logic [31:0] pipe_enq_v,
  input  logic        pipe_enq__RDY
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] HDR_WORD = {LEN[15:0], MID[15:0]};

  typedef enum logic [1:0] {
    B_HDR  = 2'd0,
    B_METH = 2'd1,
    B_VAL  = 2'd2
  } beat_t;

  beat_t         beat_q, beat_d;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          rst_d;
  logic          full, valid, push, pop;
  logic [63:0]   head;

  // Full comes straight from the registered count, so a pop this cycle
  // does not reopen the accept side until the next cycle.
  assign full  = (count == (AW+1)'(DEPTH));
  assign valid = (count != '0) && !nRST && !rst_d;
  assign head  = mem[rd_ptr];

  assign indication_heard__RDY = !full && !nRST && !rst_d;
  assign push = indication_heard__ENA && indication_heard__RDY;

  always_comb begin
    beat_d        = beat_q;
    pop           = 1'b0;
    pipe_enq_v    = 32'h0;
    pipe_enq__ENA = valid && pipe_enq__RDY;
    if (valid) begin
      case (beat_q)
        B_HDR:   pipe_enq_v = HDR_WORD;
        B_METH:  pipe_enq_v = head[31:0];
        B_VAL:   pipe_enq_v = head[63:32];
        default: pipe_enq_v = 32'h0;
      endcase
    end
    if (pipe_enq__ENA) begin
      case (beat_q)
        B_HDR:  beat_d = B_METH;
        B_METH: beat_d = B_VAL;
        default: begin
          beat_d = B_HDR;
          pop    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      beat_q <= B_HDR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rst_d  <= 1'b1;
    end else begin
      rst_d  <= 1'b0;
      beat_q <= beat_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {indication_heard_v, indication_heard_meth};
  end

endmodule

// File: tb/tb_echo_indication_output.sv
// tb/tb_echo_indication_output.sv - scoreboard bench for echo_indication_output
module tb_echo_indication_output;

  localparam logic [31:0] HDR = 32'h0003_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        heard_ena;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard_rdy;
  logic        enq_ena;
  logic [31:0] enq_v;
  logic        enq_rdy;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  echo_indication_output #(.DEPTH(4), .MID(1), .LEN(3)) dut (
    .CLK                   (clk),
    .nRST                  (rst),
    .indication_heard__ENA (heard_ena),
    .indication_heard_meth (heard_meth),
    .indication_heard_v    (heard_v),
    .indication_heard__RDY (heard_rdy),
    .pipe_enq__ENA         (enq_ena),
    .pipe_enq_v            (enq_v),
    .pipe_enq__RDY         (enq_rdy)
  );

  always #5 clk = ~clk;

  // Every emitted beat is compared against the head of the expected queue.
  always @(negedge clk) begin
    logic [31:0] e;
    if (enq_ena === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got %h expected no beat", enq_v);
      end else begin
        e = sb.pop_front();
        if (enq_v !== e) begin
          errors++;
          $display("FAIL beat_data: got %h expected %h", enq_v, e);
        end
      end
      if (enq_rdy !== 1'b1) begin
        errors++;
        $display("FAIL ena_without_rdy: got rdy=%b expected 1", enq_rdy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_call(input logic [31:0] m, input logic [31:0] val, input logic acc);
    heard_ena  = 1'b1;
    heard_meth = m;
    heard_v    = val;
    @(negedge clk);
    checks++;
    if (heard_rdy !== acc) begin
      errors++;
      $display("FAIL call_rdy: got %b expected %b (meth %0d)", heard_rdy, acc, m);
    end
    if (acc) begin
      sb.push_back(HDR);
      sb.push_back(m);
      sb.push_back(val);
    end
    step();
    heard_ena = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats pending expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enq_rdy = 1'b1; heard_ena = 1'b0; heard_meth = '0; heard_v = '0;
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_rdy", {31'h0, heard_rdy}, 32'h0);
      chk("reset_ena", {31'h0, enq_ena}, 32'h0);
      chk("reset_v", enq_v, 32'h0);
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_rdy", {31'h0, heard_rdy}, 32'h0);
    chk("post_reset_ena", {31'h0, enq_ena}, 32'h0);
    step();
    @(negedge clk);
    chk("idle_rdy", {31'h0, heard_rdy}, 32'h1);
    chk("idle_ena", {31'h0, enq_ena}, 32'h0);
    step();
  endtask

  task automatic test_single();
    enq_rdy = 1'b1;
    do_call(32'h0000_0007, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("single_ena", {31'h0, enq_ena}, 32'h1);
      step();
    end
    @(negedge clk);
    chk("single_empty_ena", {31'h0, enq_ena}, 32'h0);
    chk("single_empty_v", enq_v, 32'h0);
    step();
    drain("single");
  endtask

  task automatic test_fill();
    enq_rdy = 1'b0;
    for (int i = 0; i < 4; i++) do_call(32'(i + 1), 32'(i + 10), 1'b1);
    do_call(32'h0000_00FF, 32'h0000_00EE, 1'b0);
    enq_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fill_rdy_after_pop", {31'h0, heard_rdy}, (i == 3) ? 32'h1 : 32'h0);
      step();
    end
    drain("fill");
  endtask

  task automatic test_stall();
    enq_rdy = 1'b1;
    do_call(32'h0000_0021, 32'h0000_0031, 1'b1);
    @(negedge clk);
    chk("stall_hdr_ena", {31'h0, enq_ena}, 32'h1);
    step();
    enq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ena", {31'h0, enq_ena}, 32'h0);
      chk("stall_v_held", enq_v, 32'h0000_0021);
      step();
    end
    enq_rdy = 1'b1;
    @(negedge clk);
    chk("stall_resume_meth", enq_v, 32'h0000_0021);
    step();
    @(negedge clk);
    chk("stall_resume_val", enq_v, 32'h0000_0031);
    step();
    drain("stall");
  endtask

  task automatic test_simul();
    enq_rdy = 1'b0;
    for (int i = 0; i < 4; i++) do_call(32'(i + 20), 32'(i + 30), 1'b1);
    enq_rdy = 1'b1;
    step();
    step();
    heard_ena = 1'b1; heard_meth = 32'h99; heard_v = 32'h98;
    @(negedge clk);
    chk("simul_pop_cycle_rdy", {31'h0, heard_rdy}, 32'h0);
    step();
    @(negedge clk);
    chk("simul_retry_rdy", {31'h0, heard_rdy}, 32'h1);
    sb.push_back(HDR); sb.push_back(32'h99); sb.push_back(32'h98);
    step();
    heard_ena = 1'b0;
    @(negedge clk);
    chk("simul_refull_rdy", {31'h0, heard_rdy}, 32'h0);
    step();
    drain("simul");
  endtask

  task automatic test_reset_mid();
    enq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) do_call(32'(i + 40), 32'(i + 50), 1'b1);
    enq_rdy = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_reset_ena", {31'h0, enq_ena}, 32'h0);
      chk("mid_reset_rdy", {31'h0, heard_rdy}, 32'h0);
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_rdy", {31'h0, heard_rdy}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("mid_no_stale_beat", {31'h0, enq_ena}, 32'h0);
      chk("mid_idle_rdy", {31'h0, heard_rdy}, 32'h1);
    end
    step();
    do_call(32'h0000_0055, 32'h0000_0066, 1'b1);
    @(negedge clk);
    chk("mid_fresh_hdr", enq_v, HDR);
    step();
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stall();
    test_simul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
